mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
- Multi-precision addition sequencer that wraps the registered 16-bit adder stage.
- Accepts one wide operand pair (WIDTH*WORDS bits) over a valid/ready handshake.
- Feeds the adder one WIDTH-bit word per pass, LSW first, and chains the adder's carry-out into the next word's carry-in.
- Assembles the wide result and returns it over a valid/ready handshake. It sits directly upstream of the adder stage (drives a/b/cin) and consumes its sum/cout/overflow.

Parameters:
- WIDTH, 16, word width of the attached adder stage
- WORDS, 4, number of words per operand; operand width = WIDTH*WORDS (64 by default); legal range 2..16

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer can accept an operand pair
- op_a  input  WIDTH*WORDS  operand A
- op_b  input  WIDTH*WORDS  operand B
- op_cin  input  1  carry-in to word 0
- add_a  output  WIDTH  word to adder input a
- add_b  output  WIDTH  word to adder input b
- add_cin  output  1  carry to adder input cin
- add_sum  input  WIDTH  registered sum from adder
- add_cout  input  1  registered carry-out from adder
- add_overflow  input  1  registered signed overflow from adder
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH*WORDS  wide sum
- res_cout  output  1  carry-out of the most significant word
- res_overflow  output  1  signed overflow of the full-width addition (adder overflow of the top word)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the word index to 0.
  - Registers a_reg, b_reg, carry, result, res_cout and res_overflow all go to 0.
  - out_valid=0 and busy=0; in_ready=1 once rst deasserts.
  - An in-flight operation is discarded and produces no output.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture op_a, op_b into a_reg, b_reg; carry<=op_cin; idx<=0; go to ISSUE.
- ISSUE:
  - add_a=a_reg[idx*WIDTH +: WIDTH], add_b=b_reg word idx, add_cin=carry.
  - Unconditionally go to CAPTURE.
- CAPTURE:
  - add_sum, add_cout and add_overflow now reflect the ISSUE-cycle inputs, because the adder has one-register latency.
  - Store add_sum into result word idx; carry<=add_cout.
  - If idx==WORDS-1: res_cout<=add_cout, res_overflow<=add_overflow, go to DONE.
  - Else: idx<=idx+1, go to ISSUE.
- DONE:
  - out_valid=1; result, res_cout and res_overflow are held stable.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
- add_a, add_b and add_cin are 0 in every state except ISSUE.
- add_overflow from non-top words is ignored.
- in_ready=0 in ISSUE, CAPTURE and DONE. There is no overlap between operations, and in_valid is ignored outside IDLE.
- Latency: accept edge in cycle 0; out_valid is high in cycle 2*WORDS+1 (9 by default), assuming out_ready is high. Throughput is one operation per 2*WORDS+2 cycles.
- out_ready high while not in DONE has no effect. out_valid never drops without a handshake.
- result is registered; stale words from the previous operation remain visible until overwritten. Only the DONE value is meaningful.
- The adder stage's own reset is tied by the parent so that it is in reset whenever rst=0.

Decomposition:
- Shared package (adder_pkg): state enum (IDLE, ISSUE, CAPTURE, DONE) and an IDX_W=$clog2(WORDS) helper function.
- No sub-module. The adder stage is instantiated beside this block in the parent and connected through the add_* ports.
- The bench instantiates both blocks together.

Test Plan:
- Carry chain: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> result=0x0000_0000_0001_0000, res_cout=0, res_overflow=0, out_valid in cycle 9.
- Full wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> result=0, res_cout=1, res_overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 -> result=0x8000_0000_0000_0000, res_overflow=1, res_cout=0. Also a=b=0x8000_0000_0000_0000 -> result=0, res_cout=1, res_overflow=1.
- Carry-in only: a=b=0, cin=1 -> result=0x1. Check add_cin=1 only in word 0's ISSUE cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, a new in_valid ignored. Handshake in cycle 14 -> in_ready=1 in cycle 15.
- Reset mid-op: assert rst=0 during the CAPTURE of word 2 -> outputs zero immediately and out_valid never rises. After release, a=3, b=4 -> result=7.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the multi-precision add sequencer and its adder stage.
package adder_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StCapture,
      StDone
   } seq_state_e;

   // Width of a word index able to address 0..words-1 (at least one bit).
   function automatic int unsigned idx_w(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/adder_stage.sv
// Registered WIDTH-bit adder: sum, carry-out and signed overflow appear one cycle after a/b/cin.
module adder_stage #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   logic [WIDTH:0] raw;
   logic           ovf;

   // Combinational add; overflow when both operands share a sign the sum lacks.
   always_comb begin
      raw = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
   end

   // Output register stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         sum      <= raw[WIDTH-1:0];
         cout     <= raw[WIDTH];
         overflow <= ovf;
      end
   end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add sequencer: streams a wide operand pair LSW-first through an external
// registered adder stage, chaining carries, and returns the assembled wide sum.
module mp_add_sequencer
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*WORDS-1:0] op_a,
   input  logic [WIDTH*WORDS-1:0] op_b,
   input  logic                   op_cin,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_cin,
   input  logic [WIDTH-1:0]       add_sum,
   input  logic                   add_cout,
   input  logic                   add_overflow,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*WORDS-1:0] result,
   output logic                   res_cout,
   output logic                   res_overflow,
   output logic                   busy
);

   localparam int unsigned IdxW = idx_w(WORDS);
   localparam int unsigned OpW  = WIDTH * WORDS;

   seq_state_e      state_q, state_d;
   logic [IdxW-1:0] idx_q;
   logic [OpW-1:0]  a_q, b_q, result_q;
   logic            carry_q, res_cout_q, res_ovf_q;
   logic            accept, last;

   // Next-state and handshake/adder-drive outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      last      = (idx_q == IdxW'(WORDS - 1));
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) state_d = StIssue;
         end
         StIssue: begin
            add_a   = a_q[idx_q*WIDTH +: WIDTH];
            add_b   = b_q[idx_q*WIDTH +: WIDTH];
            add_cin = carry_q;
            state_d = StCapture;
         end
         StCapture: begin
            state_d = last ? StDone : StIssue;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      accept = in_valid && in_ready;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   // Operand capture, per-word result assembly and carry chaining.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         result_q   <= '0;
         res_cout_q <= 1'b0;
         res_ovf_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  a_q     <= op_a;
                  b_q     <= op_b;
                  carry_q <= op_cin;
                  idx_q   <= '0;
               end
            end
            StCapture: begin
               // Adder outputs now reflect the previous (ISSUE) cycle's inputs.
               result_q[idx_q*WIDTH +: WIDTH] <= add_sum;
               carry_q <= add_cout;
               if (last) begin
                  res_cout_q <= add_cout;
                  res_ovf_q  <= add_overflow;
               end else begin
                  idx_q <= idx_q + IdxW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign result       = result_q;
   assign res_cout     = res_cout_q;
   assign res_overflow = res_ovf_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer wired to adder_stage; checks against a full-width arithmetic model.
module tb_mp_add_sequencer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned WORDS = 4;
   localparam int unsigned OpW   = WIDTH * WORDS;
   localparam int          LAT   = 2 * WORDS + 1;

   logic             clk, rst;
   logic             in_valid, in_ready, op_cin;
   logic [OpW-1:0]   op_a, op_b, result;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_cout, add_overflow;
   logic             out_valid, out_ready, res_cout, res_overflow, busy;

   int n_tests = 0;
   int n_fail  = 0;

   mp_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout), .add_overflow(add_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .res_cout(res_cout), .res_overflow(res_overflow), .busy(busy)
   );

   adder_stage #(.WIDTH(WIDTH)) u_adder (
      .clk(clk), .rst(rst), .a(add_a), .b(add_b), .cin(add_cin),
      .sum(add_sum), .cout(add_cout), .overflow(add_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain full-width addition; returns {overflow, cout, sum}.
   function automatic logic [OpW+1:0] ref_add(input logic [OpW-1:0] a, b, input logic cin);
      logic [OpW:0] s;
      logic         ov;
      s  = {1'b0, a} + {1'b0, b} + {{OpW{1'b0}}, cin};
      ov = (a[OpW-1] == b[OpW-1]) && (s[OpW-1] != a[OpW-1]);
      return {ov, s};
   endfunction

   // One operation with out_ready high. Cycle 0 is the cycle the pair is offered.
   task automatic do_op(input logic [OpW-1:0] a, b, input logic cin,
                        output logic [OpW+1:0] got, output int vcyc, output logic [63:0] cmask);
      int cyc;
      got   = 'x;
      vcyc  = -1;
      cmask = '0;
      @(negedge clk);
      op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (cyc < 40 && vcyc < 0) begin
         cmask[cyc] = add_cin;
         if (out_valid) begin
            vcyc = cyc;
            got  = {res_overflow, res_cout, result};
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({out_valid, busy, res_cout, res_overflow} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000", {out_valid, busy, res_cout, res_overflow});
      end
      n_tests++;
      if (result !== '0) begin
         n_fail++; $display("FAIL reset_result: got %h want 0", result);
      end
      n_tests++;
      if ({add_a, add_b, add_cin} !== '0) begin
         n_fail++; $display("FAIL reset_adder_drive: got %h want 0", {add_a, add_b, add_cin});
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [OpW-1:0]   ta[5], tb[5];
      logic             tc[5];
      logic [OpW+1:0]   te[5], got;
      logic [63:0]      cm;
      int               vc;
      ta[0] = 64'h0000_0000_0000_FFFF; tb[0] = 64'h1; tc[0] = 0;
      te[0] = {1'b0, 1'b0, 64'h0000_0000_0001_0000};
      ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'h1; tc[1] = 0;
      te[1] = {1'b0, 1'b1, 64'h0};
      ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'h1; tc[2] = 0;
      te[2] = {1'b1, 1'b0, 64'h8000_0000_0000_0000};
      ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h8000_0000_0000_0000; tc[3] = 0;
      te[3] = {1'b1, 1'b1, 64'h0};
      ta[4] = 64'h0; tb[4] = 64'h0; tc[4] = 1;
      te[4] = {1'b0, 1'b0, 64'h1};
      for (int i = 0; i < 5; i++) begin
         do_op(ta[i], tb[i], tc[i], got, vc, cm);
         n_tests++;
         if (got !== te[i]) begin
            n_fail++; $display("FAIL directed_%0d: got %h want %h", i, got, te[i]);
         end
         n_tests++;
         if (vc != LAT) begin
            n_fail++; $display("FAIL directed_latency_%0d: got %0d want %0d", i, vc, LAT);
         end
      end
   endtask

   task automatic test_cin_only();
      logic [OpW+1:0] got;
      logic [63:0]    cm;
      int             vc;
      do_op(64'h0, 64'h0, 1'b1, got, vc, cm);
      n_tests++;
      // add_cin may only be high in word 0's ISSUE cycle (cycle 1).
      if (cm !== 64'h2) begin
         n_fail++; $display("FAIL cin_only_mask: got %h want %h", cm, 64'h2);
      end
      n_tests++;
      if (got[OpW-1:0] !== 64'h1) begin
         n_fail++; $display("FAIL cin_only_result: got %h want 1", got[OpW-1:0]);
      end
   endtask

   task automatic test_backpressure();
      logic [OpW-1:0] a, b;
      logic [OpW+1:0] exp;
      int             cyc;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp = ref_add(a, b, 1'b1);
      @(negedge clk);
      op_a = a; op_b = b; op_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (cyc < 40 && !out_valid) begin
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (cyc != LAT) begin
         n_fail++; $display("FAIL bp_latency: got %0d want %0d", cyc, LAT);
      end
      // Cycles 9..13 held; a different pair is offered from cycle 10 and must be ignored.
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if ({out_valid, in_ready, res_overflow, res_cout, result} !== {1'b1, 1'b0, exp}) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got v=%b rdy=%b %h want v=1 rdy=0 %h", k, out_valid,
                     in_ready, {res_overflow, res_cout, result}, exp);
         end
         if (k == 1) begin
            op_a = ~a; op_b = ~b; op_cin = 1'b0; in_valid = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_tests++;
      if (out_valid !== 1'b1 || cyc != 14) begin
         n_fail++; $display("FAIL bp_cycle14: got v=%b cyc=%0d want v=1 cyc=14", out_valid, cyc);
      end
      @(negedge clk);
      n_tests++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++; $display("FAIL bp_cycle15: got %b want 100", {in_ready, out_valid, busy});
      end
   endtask

   task automatic test_reset_mid_op();
      logic [OpW+1:0] got;
      logic [63:0]    cm;
      int             vc;
      int             seen;
      @(negedge clk);
      op_a = 64'h1111_2222_3333_4444; op_b = 64'h5555_6666_7777_8888; op_cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);   // now in cycle 6, CAPTURE of word 2
      rst = 1'b0;
      #1;
      n_tests++;
      if ({result, res_cout, res_overflow, out_valid, busy} !== '0) begin
         n_fail++;
         $display("FAIL midreset_clear: got %h %b%b%b%b want 0", result, res_cout, res_overflow,
                  out_valid, busy);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL midreset_no_output: got %0d valid cycles want 0", seen);
      end
      do_op(64'd3, 64'd4, 1'b0, got, vc, cm);
      n_tests++;
      if (got !== {2'b00, 64'd7} || vc != LAT) begin
         n_fail++; $display("FAIL midreset_after: got %h cyc=%0d want 7 cyc=%0d", got, vc, LAT);
      end
   endtask

   task automatic test_random();
      logic [OpW-1:0] a, b;
      logic           c;
      logic [OpW+1:0] got, exp;
      logic [63:0]    cm;
      int             vc;
      for (int i = 0; i < 24; i++) begin
         a = {$urandom, $urandom};
         case (i % 3)
            0:       b = {$urandom, $urandom};
            1:       b = ~a;           // long carry chains
            default: b = a;            // same-sign operands exercise overflow
         endcase
         c   = 1'($urandom_range(0, 1));
         exp = ref_add(a, b, c);
         do_op(a, b, c, got, vc, cm);
         n_tests++;
         if (got !== exp || vc != LAT) begin
            n_fail++;
            $display("FAIL random_%0d: a=%h b=%h cin=%b got %h cyc=%0d want %h cyc=%0d", i, a, b,
                     c, got, vc, exp, LAT);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_cin_only();
      test_backpressure();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
